// File: rtl/multi_ported_sram_pkg.sv
// Shared types and constants for the multi-ported SRAM write scheduler.
// Holds the scheduler state encoding and the conflict counter width.
package multi_ported_sram_pkg;

    localparam int CONFLICT_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } state_e;

endpackage

// File: rtl/mpsram_wr_conflict.sv
// Same-address conflict detector.
// A port is dropped when any higher-indexed port writes the same address in the same cycle.
module mpsram_wr_conflict
    import multi_ported_sram_pkg::*;
#(
    parameter int NUM_W  = 2,
    parameter int ADDR_W = 3
) (
    input  logic [NUM_W-1:0]        i_vld,
    input  logic [NUM_W*ADDR_W-1:0] i_addr,
    output logic [NUM_W-1:0]        o_drop
);

    // The highest index wins, so only comparisons against later ports can drop a port.
    always_comb begin
        o_drop = '0;
        for (int i = 0; i < NUM_W; i++) begin
            for (int j = i + 1; j < NUM_W; j++) begin
                if (i_vld[i] && i_vld[j] &&
                    (i_addr[i*ADDR_W +: ADDR_W] == i_addr[j*ADDR_W +: ADDR_W])) begin
                    o_drop[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mpsram_wr_sched.sv
// Write scheduler for a multi-ported SRAM: registers per-port writes, resolves
// same-address conflicts and runs a port-0 clear sweep on request.
module mpsram_wr_sched
    import multi_ported_sram_pkg::*;
#(
    parameter int NUM_W = 2,
    parameter int W     = 32,
    parameter int N     = 8,
    localparam int ADDR_W = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_W-1:0]          in_vld,
    input  logic [NUM_W*ADDR_W-1:0]   in_addr,
    input  logic [NUM_W*W-1:0]        in_data,
    output logic                      in_rdy,
    input  logic                      init,
    output logic                      busy_w,
    output logic [NUM_W-1:0]          wen,
    output logic [NUM_W*ADDR_W-1:0]   waddr,
    output logic [NUM_W*W-1:0]        wdata,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int SUM_W = CONFLICT_CNT_W + 1;

    state_e                    r_state;
    state_e                    w_stateNext;
    logic [CNT_W-1:0]          r_sweepCnt;
    logic [CNT_W-1:0]          w_sweepCntNext;
    logic [NUM_W-1:0]          r_wen;
    logic [NUM_W*ADDR_W-1:0]   r_waddr;
    logic [NUM_W*W-1:0]        r_wdata;
    logic [CONFLICT_CNT_W-1:0] r_conflictCnt;
    logic [CONFLICT_CNT_W-1:0] w_conflictCntNext;
    logic [SUM_W-1:0]          w_sum;
    logic [NUM_W-1:0]          w_wen;
    logic [NUM_W*ADDR_W-1:0]   w_waddr;
    logic [NUM_W*W-1:0]        w_wdata;
    logic [NUM_W-1:0]          w_xfer;
    logic [NUM_W-1:0]          w_drop;

    assign in_rdy       = (r_state == ST_IDLE);
    assign busy_w       = (r_state == ST_CLR);
    assign wen          = r_wen;
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;
    assign conflict_cnt = r_conflictCnt;
    assign w_xfer       = in_vld & {NUM_W{in_rdy}};

    mpsram_wr_conflict #(
        .NUM_W  (NUM_W),
        .ADDR_W (ADDR_W)
    ) u_conflict (
        .i_vld  (w_xfer),
        .i_addr (in_addr),
        .o_drop (w_drop)
    );

    // One spare carry bit is enough since at most NUM_W-1 ports drop per cycle.
    always_comb begin
        w_sum = {1'b0, r_conflictCnt};
        for (int i = 0; i < NUM_W; i++) begin
            w_sum = w_sum + SUM_W'(w_drop[i]);
        end
        w_conflictCntNext = w_sum[SUM_W-1] ? '1 : w_sum[CONFLICT_CNT_W-1:0];
    end

    always_comb begin
        w_stateNext    = r_state;
        w_sweepCntNext = r_sweepCnt;
        w_wen          = '0;
        w_waddr        = '0;
        w_wdata        = '0;
        case (r_state)
            ST_IDLE: begin
                w_wen   = w_xfer & ~w_drop;
                w_waddr = in_addr;
                w_wdata = in_data;
                if (init) begin
                    w_stateNext = ST_CLR;
                    // Accepted writes go out first; the sweep then starts from address 0 in CLR.
                    if (w_xfer == '0) begin
                        w_wen          = NUM_W'(1);
                        w_waddr        = '0;
                        w_wdata        = '0;
                        w_sweepCntNext = CNT_W'(1);
                    end else begin
                        w_sweepCntNext = '0;
                    end
                end
            end
            ST_CLR: begin
                if (r_sweepCnt == CNT_W'(N)) begin
                    w_stateNext    = ST_IDLE;
                    w_sweepCntNext = '0;
                end else begin
                    w_wen                = NUM_W'(1);
                    w_waddr[ADDR_W-1:0]  = r_sweepCnt[ADDR_W-1:0];
                    w_sweepCntNext       = r_sweepCnt + CNT_W'(1);
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sweepCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_sweepCnt <= w_sweepCntNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen         <= '0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_conflictCnt <= '0;
        end else begin
            r_wen         <= w_wen;
            r_waddr       <= w_waddr;
            r_wdata       <= w_wdata;
            r_conflictCnt <= w_conflictCntNext;
        end
    end

endmodule

// File: tb/tb_mpsram_wr_sched.sv
// Scoreboard bench for mpsram_wr_sched: a 2-port/8-word instance checked against a
// last-writer-wins reference model, plus a 3-port/6-word instance for sweep and saturation.
module tb_mpsram_wr_sched;

    localparam int A_NW = 2;
    localparam int A_W  = 32;
    localparam int A_N  = 8;
    localparam int A_AW = 3;
    localparam int B_NW = 3;
    localparam int B_W  = 8;
    localparam int B_N  = 6;
    localparam int B_AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rstA, initA, inRdyA, busyA;
    logic [A_NW-1:0]        vldA, wenA;
    logic [A_NW*A_AW-1:0]   addrA, waddrA;
    logic [A_NW*A_W-1:0]    dataA, wdataA;
    logic [15:0]            cntA;

    logic                   rstB, initB, inRdyB, busyB;
    logic [B_NW-1:0]        vldB, wenB;
    logic [B_NW*B_AW-1:0]   addrB, waddrB;
    logic [B_NW*B_W-1:0]    dataB, wdataB;
    logic [15:0]            cntB;

    mpsram_wr_sched #(.NUM_W(A_NW), .W(A_W), .N(A_N)) dutA (
        .clk(clk), .rst(rstA), .in_vld(vldA), .in_addr(addrA), .in_data(dataA),
        .in_rdy(inRdyA), .init(initA), .busy_w(busyA), .wen(wenA), .waddr(waddrA),
        .wdata(wdataA), .conflict_cnt(cntA)
    );

    mpsram_wr_sched #(.NUM_W(B_NW), .W(B_W), .N(B_N)) dutB (
        .clk(clk), .rst(rstB), .in_vld(vldB), .in_addr(addrB), .in_data(dataB),
        .in_rdy(inRdyB), .init(initB), .busy_w(busyB), .wen(wenB), .waddr(waddrB),
        .wdata(wdataB), .conflict_cnt(cntB)
    );

    typedef struct {
        int                   cyc;
        logic [A_NW-1:0]      wen;
        logic [A_NW*A_AW-1:0] waddr;
        logic [A_NW*A_W-1:0]  wdata;
    } exp_t;

    exp_t sbQ[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int expCntA = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: for each address the last (highest-index) valid port is the writer.
    function automatic void modelWrite(input logic [A_NW-1:0] vld, input logic [A_NW*A_AW-1:0] addr,
                                       input logic [A_NW*A_W-1:0] data, output exp_t e, output int drops);
        int winner[int];
        e.cyc = 0;
        e.wen = '0;
        e.waddr = '0;
        e.wdata = '0;
        for (int i = 0; i < A_NW; i++)
            if (vld[i]) winner[int'(addr[i*A_AW +: A_AW])] = i;
        drops = $countones(vld) - winner.num();
        for (int i = 0; i < A_NW; i++) begin
            if (vld[i] && winner[int'(addr[i*A_AW +: A_AW])] == i) begin
                e.wen[i] = 1'b1;
                e.waddr[i*A_AW +: A_AW] = addr[i*A_AW +: A_AW];
                e.wdata[i*A_W +: A_W] = data[i*A_W +: A_W];
            end
        end
    endfunction

    // Drives one cycle on dutA; when the bench expects acceptance, queues the resulting writes.
    task automatic applyStimulus(input logic [A_NW-1:0] vld, input logic [A_NW*A_AW-1:0] addr,
                                 input logic [A_NW*A_W-1:0] data, input logic ini,
                                 input bit accept, input int nSweep);
        exp_t e;
        int drops;
        int start;
        vldA = vld;
        addrA = addr;
        dataA = data;
        initA = ini;
        if (accept) begin
            start = cyc + 1;
            if (vld != '0) begin
                modelWrite(vld, addr, data, e, drops);
                e.cyc = cyc + 1;
                sbQ.push_back(e);
                expCntA += drops;
                start = cyc + 2;
            end
            if (ini) begin
                for (int k = 0; k < nSweep; k++) begin
                    e.cyc = start + k;
                    e.wen = A_NW'(1);
                    e.waddr = '0;
                    e.waddr[A_AW-1:0] = A_AW'(k);
                    e.wdata = '0;
                    sbQ.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        vldA = '0;
        initA = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever dutA issues a write and flags overdue entries.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [A_NW*A_AW-1:0] mA;
        logic [A_NW*A_W-1:0]  mD;
        if (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
            checkOutput("sb_missed_write", 64'(cyc), 64'(sbQ[0].cyc));
            void'(sbQ.pop_front());
        end
        if (wenA != '0) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected_wen", 64'(wenA), 64'd0);
            end else begin
                e = sbQ.pop_front();
                mA = '0;
                mD = '0;
                for (int i = 0; i < A_NW; i++) begin
                    if (e.wen[i]) begin
                        mA[i*A_AW +: A_AW] = '1;
                        mD[i*A_W +: A_W] = '1;
                    end
                end
                checkOutput("sb_cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("sb_wen", 64'(wenA), 64'(e.wen));
                checkOutput("sb_waddr", 64'(waddrA & mA), 64'(e.waddr));
                checkOutput("sb_wdata", 64'(wdataA & mD), 64'(e.wdata));
            end
        end
    end

    initial begin
        int nBusy;
        logic [A_NW*A_AW-1:0] ra;
        rstA = 1'b1; rstB = 1'b1;
        vldA = '0; addrA = '0; dataA = '0; initA = 1'b0;
        vldB = '0; addrB = '0; dataB = '0; initB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wen", 64'(wenA), 64'd0);
        checkOutput("rst_waddr", 64'(waddrA), 64'd0);
        checkOutput("rst_wdata", 64'(wdataA), 64'd0);
        checkOutput("rst_busy", 64'(busyA), 64'd0);
        checkOutput("rst_cnt", 64'(cntA), 64'd0);
        checkOutput("rst_rdy", 64'(inRdyA), 64'd1);
        checkOutput("rst_b_cnt", 64'(cntB), 64'd0);
        rstA = 1'b0; rstB = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(2'b11, {3'd5, 3'd3}, {32'hB, 32'hA}, 1'b0, 1'b1, 0);
        checkOutput("cnt_no_conflict", 64'(cntA), 64'(expCntA));
        applyStimulus(2'b11, {3'd4, 3'd4}, {32'h2, 32'h1}, 1'b0, 1'b1, 0);
        checkOutput("conflict_wen", 64'(wenA), 64'b10);
        checkOutput("cnt_one_conflict", 64'(cntA), 64'(expCntA));
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b1, 0);
        checkOutput("idle_wen", 64'(wenA), 64'd0);

        repeat (300) begin
            if ($urandom_range(0, 1) == 1) ra = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            else                           ra = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 1))};
            applyStimulus(2'($urandom_range(0, 3)), ra, {$urandom, $urandom}, 1'b0, 1'b1, 0);
        end
        checkOutput("cnt_random", 64'(cntA), 64'(expCntA));

        // Plain clear sweep; junk requests and a second init during the sweep must be ignored.
        applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, A_N);
        nBusy = 0;
        for (int k = 0; k < 12; k++) begin
            if (!busyA) break;
            nBusy++;
            checkOutput("clr_rdy", 64'(inRdyA), 64'd0);
            applyStimulus(2'($urandom_range(0, 3)), {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))},
                          {$urandom, $urandom}, (k == 2), 1'b0, 0);
        end
        checkOutput("clr_busy_len", 64'(nBusy), 64'(A_N));
        checkOutput("post_clr_rdy", 64'(inRdyA), 64'd1);

        // init together with writes: writes first, then a full sweep.
        applyStimulus(2'b11, {3'd6, 3'd1}, {32'h66, 32'h11}, 1'b1, 1'b1, A_N);
        for (int k = 0; k < 20; k++) begin
            if (!busyA) break;
            applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, 0);
        end
        checkOutput("init_with_writes_end", 64'(busyA), 64'd0);

        // Reset during the third sweep write aborts the sweep.
        applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 3);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, 0);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, 0);
        rstA = 1'b1;
        @(posedge clk);
        #1;
        expCntA = 0;
        checkOutput("abort_wen", 64'(wenA), 64'd0);
        checkOutput("abort_busy", 64'(busyA), 64'd0);
        checkOutput("abort_cnt", 64'(cntA), 64'd0);
        rstA = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_rdy", 64'(inRdyA), 64'd1);
        repeat (12) applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, 0);
        checkOutput("abort_busy_after", 64'(busyA), 64'd0);

        // Non-power-of-two sweep on dutB.
        initB = 1'b1;
        @(posedge clk);
        #1;
        initB = 1'b0;
        nBusy = 0;
        for (int k = 0; k < 10; k++) begin
            if (!busyB) break;
            checkOutput("b_wen", 64'(wenB), 64'b001);
            checkOutput("b_waddr", 64'(waddrB[B_AW-1:0]), 64'(k));
            checkOutput("b_wdata", 64'(wdataB), 64'd0);
            checkOutput("b_rdy", 64'(inRdyB), 64'd0);
            nBusy++;
            @(posedge clk);
            #1;
        end
        checkOutput("b_busy_len", 64'(nBusy), 64'(B_N));

        // Two drops per cycle for 32767 cycles reaches 16'hFFFE, then saturates.
        vldB = 3'b111;
        addrB = {3'd2, 3'd2, 3'd2};
        dataB = 24'h332211;
        repeat (32767) @(posedge clk);
        #1;
        checkOutput("b_cnt_fffe", 64'(cntB), 64'hFFFE);
        checkOutput("b_conflict_wen", 64'(wenB), 64'b100);
        checkOutput("b_conflict_addr", 64'(waddrB[2*B_AW +: B_AW]), 64'd2);
        @(posedge clk);
        #1;
        checkOutput("b_cnt_sat", 64'(cntB), 64'hFFFF);
        @(posedge clk);
        #1;
        checkOutput("b_cnt_hold", 64'(cntB), 64'hFFFF);
        vldB = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drain", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpsram_wr_sched.md
MPSRAM_WR_SCHED -- requirements
Module: mpsram_wr_sched

Interface
REQ-001 Parameter NUM_W, default 2: number of write ports; minimum 1.
REQ-002 Parameter W, default 32: data width in bits.
REQ-003 Parameter N, default 8: number of words; minimum 2; need not be a power of two; ADDR_W = $clog2(N).
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset; synchronous, active-high.
REQ-006 Port in_vld, input, NUM_W: per-port write request valid.
REQ-007 Port in_addr, input, NUM_W*ADDR_W: per-port address; port i occupies slice [i*ADDR_W +: ADDR_W].
REQ-008 Port in_data, input, NUM_W*W: per-port write data; port i occupies slice [i*W +: W].
REQ-009 Port in_rdy, output, 1: common ready for all write ports; a port transfers when in_vld[i] && in_rdy.
REQ-010 Port init, input, 1: single-cycle request to clear the whole memory.
REQ-011 Port busy_w, output, 1: high while the clear sweep is in progress.
REQ-012 Port wen, output, NUM_W: registered write enables to the downstream multi-ported memory.
REQ-013 Port waddr, output, NUM_W*ADDR_W: registered write addresses, packed as in_addr.
REQ-014 Port wdata, output, NUM_W*W: registered write data, packed as in_data.
REQ-015 Port conflict_cnt, output, 16: count of dropped writes; saturates at 16'hFFFF.

Function
REQ-016 The block SHALL implement an FSM with two states: IDLE and CLR.
- IDLE -> CLR: init=1.
- CLR -> IDLE: the cycle the sweep writes address N-1.
REQ-017 In IDLE, in_rdy SHALL be 1. In CLR, in_rdy SHALL be 0.
REQ-018 busy_w SHALL equal (state == CLR), taken directly from the state register.
REQ-019 In IDLE, each transferred port i SHALL appear on wen[i], waddr slice i and wdata slice i exactly one cycle later; wen[i] = 0 for ports that did not transfer.
REQ-020 Same-address conflict: when ports i<j both transfer with equal addresses in one cycle, port j (highest index) SHALL win and port i's wen SHALL be 0.
REQ-021 conflict_cnt SHALL increase by the number of ports dropped that cycle (0..NUM_W-1), saturating at 16'hFFFF.
REQ-022 CLR sweep: one write per cycle on port 0 only.
- Output values: wen = 1 on port 0, wdata = 0.
- Address: waddr increments 0, 1, ..., N-1; the first sweep write appears the cycle after init is sampled.
- Duration: exactly N cycles with busy_w = 1.
REQ-023 init sampled while in CLR SHALL be ignored; the sweep does not restart.
REQ-024 init and in_vld high in the same IDLE cycle: the writes SHALL be accepted and issued first, and the sweep SHALL follow, so the sweep overwrites them.
REQ-025 The sweep address counter SHALL terminate at N-1 for non-power-of-two N and never emit an address >= N.
REQ-026 In IDLE with no transfers, all wen bits SHALL be 0.

Reset
REQ-027 While rst=1:
- state = IDLE, sweep counter = 0, conflict_cnt = 0.
- wen = 0, waddr = 0, wdata = 0, busy_w = 0.
REQ-028 rst asserted mid-sweep SHALL abort the sweep; after rst deasserts, in_rdy = 1 in the first cycle and no further sweep writes are issued.

Structure
REQ-029 The FSM state enum and the conflict counter width constant (16) SHALL live in multi_ported_sram_pkg.
REQ-030 Conflict detection (pairwise address compare producing a NUM_W-bit drop mask) SHALL be a single sub-module, mpsram_wr_conflict, which is purely combinational.
REQ-031 All outputs SHALL be driven from flops; there are no combinational paths from inputs to outputs.

Verification
REQ-032 NUM_W=2, N=8: port0 addr 3 data 0xA, port1 addr 5 data 0xB -> next cycle wen=2'b11 with those addresses and data; conflict_cnt=0.
REQ-033 Both ports write addr 4 (data 0x1 on port0, 0x2 on port1) -> wen=2'b10, waddr slice1 = 4, wdata slice1 = 0x2; conflict_cnt=1.
REQ-034 init pulse, N=8 -> busy_w high for 8 cycles; port-0 addresses 0..7 with data 0; in_rdy = 0 throughout; then IDLE.
REQ-035 N=6, init -> addresses 0..5 only; busy_w high for exactly 6 cycles.
REQ-036 rst asserted at the third sweep cycle -> wen=0 and busy_w=0 the next cycle; no sweep writes after rst deasserts.
REQ-037 Force conflict_cnt to 16'hFFFE, then one cycle with 2 drops (NUM_W=3, all ports same address) -> conflict_cnt = 16'hFFFF.
